// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access controller.
//   cmd_op_e : command opcodes carried on cmd_op
//   state_e  : controller FSM states
//   *_DEF    : default data width, address width and register count
package regfile_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int NREGS_DEF = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ2 = 2'd2,
        OP_DUMP  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_RADDR     = 3'd2,
        S_RSP       = 3'd3,
        S_DUMP_ADDR = 3'd4,
        S_DUMP_RSP  = 3'd5
    } state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for a 3-port register file (two combinational
// read ports, one synchronous write port). Accepts WRITE / READ2 / DUMP
// commands on a valid/ready channel and returns read words on a
// valid/ready response channel. Every output is driven from a register.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op                     0=NOP 1=WRITE 2=READ2 3=DUMP
//   cmd_addr_a/cmd_addr_b      write/first-read address, second-read address
//   cmd_data                   write data
//   rsp_valid/rsp_ready        response handshake
//   rsp_addr                   address that produced rsp_data_a
//   rsp_data_a/rsp_data_b      read words
//   rsp_last                   final beat of a command
//   rf_we/rf_wa/rf_wd          register-file write port
//   rf_ra1/rf_ra2              register-file read addresses
//   rf_rd1/rf_rd2              register-file read data
//   busy                       controller not in IDLE
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr_a,
    input  logic [AW-1:0] cmd_addr_b,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data_a,
    output logic [DW-1:0] rsp_data_b,
    output logic          rsp_last,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [AW-1:0] rf_ra1,
    output logic [AW-1:0] rf_ra2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic          busy
);

    // Dump pair index: registers 2k and 2k+1 are read together.
    localparam int KW = AW - 1;
    localparam logic [KW-1:0] K_LAST = KW'(NREGS / 2 - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] k_inc;

    logic          cmd_ready_d, busy_d, rf_we_d, rsp_valid_d, rsp_last_d;
    logic [AW-1:0] rf_wa_d, rf_ra1_d, rf_ra2_d, rsp_addr_d;
    logic [DW-1:0] rf_wd_d, rsp_data_a_d, rsp_data_b_d;

    logic accept;
    logic rsp_xfer;

    assign accept   = cmd_valid && cmd_ready;
    assign rsp_xfer = rsp_valid && rsp_ready;
    assign k_inc    = k_q + KW'(1);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        rf_we_d      = 1'b0;
        rf_wa_d      = rf_wa;
        rf_wd_d      = rf_wd;
        rf_ra1_d     = rf_ra1;
        rf_ra2_d     = rf_ra2;
        rsp_valid_d  = rsp_valid;
        rsp_addr_d   = rsp_addr;
        rsp_data_a_d = rsp_data_a;
        rsp_data_b_d = rsp_data_b;
        rsp_last_d   = rsp_last;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op_e'(cmd_op))
                        OP_WRITE: begin
                            // Write port is loaded at accept so we3 is high
                            // for exactly the single WRITE-state cycle.
                            state_d = S_WRITE;
                            rf_we_d = 1'b1;
                            rf_wa_d = cmd_addr_a;
                            rf_wd_d = cmd_data;
                        end
                        OP_READ2: begin
                            state_d  = S_RADDR;
                            rf_ra1_d = cmd_addr_a;
                            rf_ra2_d = cmd_addr_b;
                        end
                        OP_DUMP: begin
                            state_d  = S_DUMP_ADDR;
                            k_d      = '0;
                            rf_ra1_d = '0;
                            rf_ra2_d = AW'(1);
                        end
                        default: ;
                    endcase
                end
            end

            S_WRITE: state_d = S_IDLE;

            S_RADDR: begin
                // Read ports are combinational: the words are valid now.
                rsp_data_a_d = rf_rd1;
                rsp_data_b_d = rf_rd2;
                rsp_addr_d   = rf_ra1;
                rsp_last_d   = 1'b1;
                rsp_valid_d  = 1'b1;
                state_d      = S_RSP;
            end

            S_RSP: begin
                if (rsp_xfer) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            S_DUMP_ADDR: begin
                rsp_data_a_d = rf_rd1;
                rsp_data_b_d = rf_rd2;
                rsp_addr_d   = {k_q, 1'b0};
                rsp_last_d   = (k_q == K_LAST);
                rsp_valid_d  = 1'b1;
                state_d      = S_DUMP_RSP;
            end

            S_DUMP_RSP: begin
                if (rsp_xfer) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last) begin
                        state_d = S_IDLE;
                    end else begin
                        k_d      = k_inc;
                        rf_ra1_d = {k_inc, 1'b0};
                        rf_ra2_d = {k_inc, 1'b1};
                        state_d  = S_DUMP_ADDR;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Ready/busy are registered, so they follow the next state.
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            rf_ra1     <= '0;
            rf_ra2     <= '0;
            rsp_valid  <= 1'b0;
            rsp_addr   <= '0;
            rsp_data_a <= '0;
            rsp_data_b <= '0;
            rsp_last   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cmd_ready  <= cmd_ready_d;
            busy       <= busy_d;
            rf_we      <= rf_we_d;
            rf_wa      <= rf_wa_d;
            rf_wd      <= rf_wd_d;
            rf_ra1     <= rf_ra1_d;
            rf_ra2     <= rf_ra2_d;
            rsp_valid  <= rsp_valid_d;
            rsp_addr   <= rsp_addr_d;
            rsp_data_a <= rsp_data_a_d;
            rsp_data_b <= rsp_data_b_d;
            rsp_last   <= rsp_last_d;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a behavioural register file is wired to the
// rf_* ports and a plain array holds the expected register contents.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr_a, cmd_addr_b;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data_a, rsp_data_b;
    logic          rf_we;
    logic [AW-1:0] rf_wa, rf_ra1, rf_ra2;
    logic [DW-1:0] rf_wd, rf_rd1, rf_rd2;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Register file attached to the controller.
    logic          rf_clr;
    logic [DW-1:0] rf_mem [32];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_we && rf_wa != 0) begin
            rf_mem[rf_wa] <= rf_wd;
        end
    end
    assign rf_rd1 = (rf_ra1 == 0) ? '0 : rf_mem[rf_ra1];
    assign rf_rd2 = (rf_ra2 == 0) ? '0 : rf_mem[rf_ra2];

    // Expected register contents.
    logic [DW-1:0] model [32];

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DW(DW), .AW(AW), .NREGS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr_a (cmd_addr_a),
        .cmd_addr_b (cmd_addr_b),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_addr   (rsp_addr),
        .rsp_data_a (rsp_data_a),
        .rsp_data_b (rsp_data_b),
        .rsp_last   (rsp_last),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expv(input logic [4:0] a);
        return (a == 0) ? 32'd0 : model[a];
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command and return in the cycle after it is accepted.
    task automatic issue(input cmd_op_e op, input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] d);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_data   = d;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("issue_ready_timeout", 32'(n < 50), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        issue(OP_WRITE, a, 5'd0, d);
        check("wr_we", rf_we, 1);
        check("wr_wa", rf_wa, a);
        check("wr_wd", rf_wd, d);
        check("wr_cmd_ready", cmd_ready, 0);
        tick();
        check("wr_we_drop", rf_we, 0);
        check("wr_back_idle", cmd_ready, 1);
        if (a != 0) model[a] = d;
    endtask

    // READ2 with 'stall' cycles of rsp_ready=0 once the beat is valid.
    task automatic do_read(input logic [4:0] a, input logic [4:0] b, input int stall);
        rsp_ready = 1'b0;
        issue(OP_READ2, a, b, 32'd0);
        check("rd_not_yet_valid", rsp_valid, 0);
        check("rd_busy", busy, 1);
        tick();
        check("rd_latency_valid", rsp_valid, 1);
        for (int i = 0; i < stall; i++) begin
            check("rd_stall_valid", rsp_valid, 1);
            check("rd_stall_cmd_ready", cmd_ready, 0);
            check("rd_stall_data_a", rsp_data_a, expv(a));
            check("rd_stall_data_b", rsp_data_b, expv(b));
            tick();
        end
        check("rd_data_a", rsp_data_a, expv(a));
        check("rd_data_b", rsp_data_b, expv(b));
        check("rd_addr", rsp_addr, a);
        check("rd_last", rsp_last, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_valid_drop", rsp_valid, 0);
        check("rd_back_idle", cmd_ready, 1);
        check("rd_busy_drop", busy, 0);
    endtask

    task automatic do_dump(input bit toggle);
        int beats = 0;
        int n = 0;
        bit rr = 1'b0;
        rsp_ready = 1'b0;
        issue(OP_DUMP, 5'd0, 5'd0, 32'd0);
        while (beats < 16 && n < 400) begin
            rr = toggle ? ~rr : 1'b1;
            rsp_ready = rr;
            if (rsp_valid) begin
                check("dump_addr", rsp_addr, 32'(2 * beats));
                check("dump_a", rsp_data_a, expv(5'(2 * beats)));
                check("dump_b", rsp_data_b, expv(5'(2 * beats + 1)));
                check("dump_last", rsp_last, 32'(beats == 15));
                if (rr) beats++;
            end
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        check("dump_beats", beats, 16);
        check("dump_valid_drop", rsp_valid, 0);
        check("dump_back_idle", cmd_ready, 1);
        check("dump_busy_drop", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int n;
        rst_n = 1'b0;
        rf_clr = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = OP_NOP;
        cmd_addr_a = '0;
        cmd_addr_b = '0;
        cmd_data = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_rsp_data_a", rsp_data_a, 0);
        #2;
        rst_n = 1'b1;
        rf_clr = 1'b0;
        tick();

        // Write then read
        do_write(5'd18, 32'd255);
        do_write(5'd19, 32'd170);
        do_read(5'd18, 5'd19, 0);

        // Register 0
        do_write(5'd0, 32'hDEADBEEF);
        do_read(5'd0, 5'd18, 0);

        // Backpressure
        do_read(5'd18, 5'd19, 5);

        // NOP: accepted, no side effects
        issue(OP_NOP, 5'd3, 5'd4, 32'h1111);
        check("nop_we", rf_we, 0);
        check("nop_busy", busy, 0);
        check("nop_rsp_valid", rsp_valid, 0);
        check("nop_cmd_ready", cmd_ready, 1);
        tick();
        check("nop_we_later", rf_we, 0);
        check("nop_rsp_later", rsp_valid, 0);
        do_read(5'd3, 5'd4, 0);

        // WRITE offered while a response is pending
        rsp_ready = 1'b0;
        issue(OP_READ2, 5'd18, 5'd19, 32'd0);
        cmd_valid  = 1'b1;
        cmd_op     = OP_WRITE;
        cmd_addr_a = 5'd7;
        cmd_data   = 32'h0000_1234;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("busy_rej_cmd_ready", cmd_ready, 0);
            check("busy_rej_we", rf_we, 0);
            check("busy_rej_valid", rsp_valid, 1);
            tick();
        end
        check("busy_rej_data_a", rsp_data_a, 32'd255);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("busy_rej_idle", cmd_ready, 1);
        check("busy_rej_we_idle", rf_we, 0);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        check("busy_late_we", rf_we, 1);
        check("busy_late_wa", rf_wa, 7);
        check("busy_late_wd", rf_wd, 32'h1234);
        tick();
        model[7] = 32'h1234;
        do_read(5'd7, 5'd18, 0);

        // Randomised writes and reads against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(5'($urandom_range(0, 31)), $urandom);
            else
                do_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        $urandom_range(0, 3));
        end

        // Dump with preload rN = 3N
        for (int r = 1; r < 32; r++) do_write(5'(r), 32'(3 * r));
        do_dump(1'b1);

        // Reset in the middle of a dump
        rsp_ready = 1'b1;
        issue(OP_DUMP, 5'd0, 5'd0, 32'd0);
        beats = 0;
        n = 0;
        while (beats < 5 && n < 100) begin
            if (rsp_valid) beats++;
            tick();
            n++;
        end
        check("mid_dump_reach_beat5", beats, 5);
        check("mid_dump_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_valid", rsp_valid, 0);
        do_dump(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
